vertex_xform_sched: RTL and testbench

Sequencer for triangle vertex transformation. It owns the 4x4 Q16.16 transform matrix and one shared signed fixed-point multiply-accumulate unit. For each accepted triangle it iterates that unit over 3 vertices × 4 rows × 3 columns, then presents clip-space x/y/z/w for all three vertices on a valid/stall handshake. It sits between triangle fetch (upstream) and the viewport/rasteriser stage (downstream).

---
 rtl/vertex_xform_sched.sv | 128 ++++++++++++
 tb/tb_vertex_xform_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vertex_xform_sched.sv
// vertex_xform_sched: drives one shared Q16.16 MAC over 3 vertices x 4 rows x 3 cols per triangle
//   clock, reset               system clock, asynchronous active-high reset
//   mat_wr_en/addr/data        4x4 row-major Q16.16 matrix write port, honoured only while idle
//   v_in[15x32]                x1 y1 z1 rgb1 x2 y2 z2 rgb2 x3 y3 z3 rgb3 nx ny nz (rgb/normals unused)
//   input_data_valid, done_in  triangle offer and end-of-frame marker, sampled on accept
//   stall_in                   downstream not ready
//   x/y/z/w_out[3x32]          clip-space results, vertex i at bits [i*32 +: 32]
//   out_data_valid, done_out   results valid; one-cycle end-of-frame pulse on consumption
//   stall_out                  busy, triangle offers ignored
module vertex_xform_sched #(
  parameter int MAT_DEPTH = 16,
  parameter int FRAC_BITS = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mat_wr_en,
  input  logic [3:0]    mat_wr_addr,
  input  logic [31:0]   mat_wr_data,
  input  logic [479:0]  v_in,
  input  logic          input_data_valid,
  input  logic          done_in,
  input  logic          stall_in,
  output logic [95:0]   x_out,
  output logic [95:0]   y_out,
  output logic [95:0]   z_out,
  output logic [95:0]   w_out,
  output logic          out_data_valid,
  output logic          done_out,
  output logic          stall_out
);
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_mat [MAT_DEPTH];
  logic [31:0] r_v [9];
  logic [31:0] r_res [12];
  logic [31:0] r_acc;
  logic [1:0]  r_vtx, r_row, r_col;
  logic        r_done;
  logic [3:0]  w_vidx;
  logic [31:0] w_m, w_vv, w_term, w_base, w_sum;
  logic [63:0] w_prod;
  logic        w_last;
  logic        w_unused;
  assign stall_out = (r_state != IDLE);
  assign w_unused  = ^{v_in, w_prod};
  always_comb begin
    w_vidx = {1'b0, r_vtx, 1'b0} + {2'b00, r_vtx} + {2'b00, r_col};
    w_m    = r_mat[{r_row, r_col}];
    w_vv   = r_v[w_vidx];
    // sign-extended operands make the low 64 bits the exact signed product
    w_prod = {{32{w_m[31]}}, w_m} * {{32{w_vv[31]}}, w_vv};
    w_term = w_prod[FRAC_BITS +: 32];
    // column 0 seeds with the translation column (implicit w = 1.0)
    w_base = (r_col == 2'd0) ? r_mat[{r_row, 2'd3}] : r_acc;
    w_sum  = w_base + w_term;
    w_last = (r_vtx == 2'd2) && (r_row == 2'd3) && (r_col == 2'd2);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = input_data_valid ? CALC : IDLE;
      CALC:    w_next = w_last ? OUT : CALC;
      default: w_next = stall_in ? OUT : IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_acc          <= '0;
      r_vtx          <= '0;
      r_row          <= '0;
      r_col          <= '0;
      r_done         <= 1'b0;
      out_data_valid <= 1'b0;
      done_out       <= 1'b0;
      x_out          <= '0;
      y_out          <= '0;
      z_out          <= '0;
      w_out          <= '0;
      for (int i = 0; i < MAT_DEPTH; i++) r_mat[i] <= '0;
      for (int i = 0; i < 9; i++) r_v[i] <= '0;
      for (int i = 0; i < 12; i++) r_res[i] <= '0;
    end else begin
      r_state  <= w_next;
      done_out <= 1'b0;
      case (r_state)
        IDLE: begin
          // the write lands on the accept edge, so the new triangle sees it
          if (mat_wr_en) r_mat[mat_wr_addr] <= mat_wr_data;
          if (input_data_valid) begin
            for (int v = 0; v < 3; v++)
              for (int c = 0; c < 3; c++)
                r_v[v*3+c] <= v_in[(v*4+c)*32 +: 32];
            r_done <= done_in;
            r_vtx  <= '0;
            r_row  <= '0;
            r_col  <= '0;
          end
        end
        CALC: begin
          r_acc <= w_sum;
          if (r_col == 2'd2) r_res[{r_vtx, r_row}] <= w_sum;
          r_col <= (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
          r_row <= (r_col == 2'd2) ? r_row + 2'd1 : r_row;
          r_vtx <= (r_col == 2'd2 && r_row == 2'd3) ? r_vtx + 2'd1 : r_vtx;
          // results are staged during CALC and published together so the
          // visible outputs never show a half-transformed triangle
          if (w_last) begin
            out_data_valid <= 1'b1;
            for (int v = 0; v < 3; v++) begin
              x_out[v*32 +: 32] <= r_res[v*4];
              y_out[v*32 +: 32] <= r_res[v*4+1];
              z_out[v*32 +: 32] <= r_res[v*4+2];
              w_out[v*32 +: 32] <= r_res[v*4+3];
            end
            w_out[95:64] <= w_sum;
          end
        end
        default: begin
          if (!stall_in) begin
            out_data_valid <= 1'b0;
            done_out       <= r_done;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vertex_xform_sched.sv
// tb_vertex_xform_sched: directed and randomized checks of vertex_xform_sched against an arithmetic model
module tb_vertex_xform_sched;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         mat_wr_en = 1'b0;
  logic [3:0]   mat_wr_addr = '0;
  logic [31:0]  mat_wr_data = '0;
  logic [479:0] v_in = '0;
  logic         input_data_valid = 1'b0;
  logic         done_in = 1'b0;
  logic         stall_in = 1'b0;
  logic [95:0]  x_out, y_out, z_out, w_out;
  logic         out_data_valid, done_out, stall_out;
  int           total = 0;
  int           bad = 0;
  logic [31:0]  m [16];
  logic [31:0]  tv [9];
  vertex_xform_sched dut (
    .clock(clock), .reset(reset),
    .mat_wr_en(mat_wr_en), .mat_wr_addr(mat_wr_addr), .mat_wr_data(mat_wr_data),
    .v_in(v_in), .input_data_valid(input_data_valid), .done_in(done_in), .stall_in(stall_in),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .w_out(w_out),
    .out_data_valid(out_data_valid), .done_out(done_out), .stall_out(stall_out)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // clip coordinate = translation + sum of (matrix * vertex) each scaled by 2^-16 rounding down
  function automatic logic [31:0] xf(int vv, int r);
    longint acc;
    acc = longint'($signed(m[r*4+3]));
    for (int c = 0; c < 3; c++)
      acc += (longint'($signed(m[r*4+c])) * longint'($signed(tv[vv*3+c]))) >>> 16;
    return acc[31:0];
  endfunction
  function automatic logic [95:0] row_exp(int r);
    return {xf(2, r), xf(1, r), xf(0, r)};
  endfunction
  task automatic write_mat(input int a, input logic [31:0] d);
    @(negedge clock);
    mat_wr_en = 1'b1;
    mat_wr_addr = 4'(a);
    mat_wr_data = d;
    @(negedge clock);
    mat_wr_en = 1'b0;
    m[a] = d;
  endtask
  task automatic load_identity();
    for (int i = 0; i < 16; i++) write_mat(i, (i % 5 == 0) ? 32'h0001_0000 : 32'h0);
  endtask
  task automatic drive_tri();
    for (int k = 0; k < 15; k++) v_in[k*32 +: 32] = $urandom;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 3; c++)
        v_in[(v*4+c)*32 +: 32] = tv[v*3+c];
  endtask
  task automatic run_tri(input bit dn, input int stall_n, input bit wr_mid);
    logic [383:0] held;
    int n;
    @(negedge clock);
    held = {x_out, y_out, z_out, w_out};
    drive_tri();
    done_in = dn;
    input_data_valid = 1'b1;
    stall_in = (stall_n > 0);
    chk("idle_not_busy", stall_out, 1'b0);
    @(negedge clock);
    input_data_valid = 1'b0;
    done_in = 1'b0;
    for (int k = 0; k < 15; k++) v_in[k*32 +: 32] = $urandom;
    chk("busy_after_accept", stall_out, 1'b1);
    n = 0;
    while (!out_data_valid && n < 100) begin
      mat_wr_en = (n == 10) && wr_mid;
      mat_wr_addr = 4'd0;
      mat_wr_data = 32'h0007_0000;
      if (n == 20) chk("calc_outputs_hold", {x_out, y_out, z_out, w_out}, held);
      @(negedge clock);
      n++;
    end
    mat_wr_en = 1'b0;
    chk("latency", n, 36);
    chk("x_out", x_out, row_exp(0));
    chk("y_out", y_out, row_exp(1));
    chk("z_out", z_out, row_exp(2));
    chk("w_out", w_out, row_exp(3));
    held = {x_out, y_out, z_out, w_out};
    for (int s = 0; s < stall_n; s++) begin
      input_data_valid = (s < stall_n - 1);
      for (int k = 0; k < 15; k++) v_in[k*32 +: 32] = $urandom;
      @(negedge clock);
      chk("stall_hold", {out_data_valid, stall_out, done_out, x_out, y_out, z_out, w_out}, {3'b110, held});
    end
    input_data_valid = 1'b0;
    stall_in = 1'b0;
    @(negedge clock);
    chk("consume", {out_data_valid, stall_out, done_out}, {2'b00, dn});
    @(negedge clock);
    chk("done_one_cycle", {out_data_valid, stall_out, done_out}, 3'b000);
  endtask
  initial begin
    bit seen;
    for (int i = 0; i < 16; i++) m[i] = '0;
    for (int i = 0; i < 9; i++) tv[i] = '0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {out_data_valid, stall_out, done_out, x_out, y_out, z_out, w_out}, '0);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_idle", stall_out, 1'b0);
    load_identity();
    for (int i = 0; i < 9; i++) tv[i] = $urandom & 32'h00FF_FFFF;
    tv[0] = 32'h0001_0000; tv[1] = 32'h0002_0000; tv[2] = 32'h0003_0000;
    run_tri(1'b0, 0, 1'b0);
    chk("ident_v0", {x_out[31:0], y_out[31:0], z_out[31:0], w_out[31:0]},
        {32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000});
    write_mat(3, 32'h0005_0000);
    write_mat(7, 32'hFFFF_0000);
    run_tri(1'b0, 1, 1'b0);
    chk("translate_v0", {x_out[31:0], y_out[31:0]}, {32'h0006_0000, 32'h0001_0000});
    write_mat(3, 32'h0);
    write_mat(7, 32'h0);
    write_mat(0, 32'hFFFF_0000);
    tv[0] = 32'h0002_8000; tv[1] = 32'h0; tv[2] = 32'h0;
    run_tri(1'b0, 0, 1'b0);
    chk("neg_scale", x_out[31:0], 32'hFFFD_8000);
    write_mat(0, 32'h7FFF_0000);
    tv[0] = 32'h0002_0000;
    run_tri(1'b0, 0, 1'b0);
    chk("wrap_no_sat", x_out[31:0], 32'hFFFE_0000);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 16; i++) write_mat(i, $urandom);
      for (int i = 0; i < 9; i++) tv[i] = $urandom;
      run_tri(1'b0, $urandom_range(0, 3), 1'b0);
    end
    load_identity();
    for (int i = 0; i < 9; i++) tv[i] = $urandom;
    run_tri(1'b0, 10, 1'b0);
    run_tri(1'b0, 0, 1'b1);
    for (int i = 0; i < 9; i++) tv[i] = $urandom;
    run_tri(1'b0, 1, 1'b0);
    write_mat(0, 32'h0007_0000);
    tv[0] = 32'h0001_0000; tv[1] = 32'h0; tv[2] = 32'h0;
    run_tri(1'b0, 0, 1'b0);
    chk("idle_write_used", x_out[31:0], 32'h0007_0000);
    run_tri(1'b1, 2, 1'b0);
    @(negedge clock);
    for (int i = 0; i < 9; i++) tv[i] = $urandom;
    drive_tri();
    done_in = 1'b1;
    input_data_valid = 1'b1;
    @(negedge clock);
    input_data_valid = 1'b0;
    done_in = 1'b0;
    repeat (20) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("reset_mid_calc", {out_data_valid, stall_out, done_out, x_out, y_out, z_out, w_out}, '0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen |= done_out | out_data_valid | stall_out;
    end
    chk("abandoned_no_output", seen, 1'b0);
    for (int i = 0; i < 9; i++) tv[i] = $urandom;
    run_tri(1'b0, 0, 1'b0);
    chk("matrix_cleared", {x_out, y_out, z_out, w_out}, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
